// File: rtl/instqueue_issue_ctrl.sv
// ---------------------------------------------------------------------------
// instqueue_issue_ctrl
//
// Purpose:
//   Instruction queue between instruction fetch and the decoder. Fetched
//   {inst, pc} pairs are buffered in a circular FIFO of 2**DEPTH_LOG entries.
//   At most one instruction per cycle is issued to the decoder through a
//   registered output stage. The queue can be flushed by the decoder (JAL
//   redirect) or by the ROB (branch mispredict).
//
// Ports:
//   clk_in                         clock, rising edge
//   rst_n_in                       asynchronous active-low reset
//   rdy_in                         global ready; low freezes the queue
//   if_instqueue_en_in             push strobe from IF
//   if_instqueue_inst_in           instruction to push
//   if_instqueue_pc_in             PC of the pushed instruction
//   instqueue_if_full_out          queue full; IF must not push
//   dispatcher_instqueue_stall_in  downstream cannot accept; blocks pops
//   decoder_instqueue_rst_in       flush request from the decoder
//   rob_instqueue_rst_in           flush request from the ROB
//   instqueue_decoder_en_out       one-cycle valid pulse per issued entry
//   instqueue_decoder_inst_out     issued instruction
//   instqueue_decoder_pc_out       issued PC
//   instqueue_count_out            current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module instqueue_issue_ctrl #(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_LOG  = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  if_instqueue_en_in,
    input  logic [INST_WIDTH-1:0] if_instqueue_inst_in,
    input  logic [ADDR_WIDTH-1:0] if_instqueue_pc_in,
    output logic                  instqueue_if_full_out,
    input  logic                  dispatcher_instqueue_stall_in,
    input  logic                  decoder_instqueue_rst_in,
    input  logic                  rob_instqueue_rst_in,
    output logic                  instqueue_decoder_en_out,
    output logic [INST_WIDTH-1:0] instqueue_decoder_inst_out,
    output logic [ADDR_WIDTH-1:0] instqueue_decoder_pc_out,
    output logic [DEPTH_LOG:0]    instqueue_count_out
);

    localparam int DEPTH = 2 ** DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] DEPTH_CNT = (DEPTH_LOG + 1)'(DEPTH);

    logic [INST_WIDTH-1:0] inst_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];

    logic [DEPTH_LOG-1:0] head;
    logic [DEPTH_LOG-1:0] tail;
    logic [DEPTH_LOG:0]   count;

    logic full;
    logic empty;
    logic flush;
    logic do_push;
    logic do_pop;

    // Full is judged by occupancy rather than pointer equality, because head
    // and tail coincide both when the queue is empty and when it is full.
    // Both strobes use the pre-edge full/empty, so a push into a full queue
    // is dropped even when a pop happens in the same cycle, and a freshly
    // pushed entry is never popped in the cycle it arrives.
    always_comb begin
        full    = (count == DEPTH_CNT);
        empty   = (count == '0);
        flush   = decoder_instqueue_rst_in | rob_instqueue_rst_in;
        do_push = rdy_in & if_instqueue_en_in & ~full & ~flush;
        do_pop  = rdy_in & ~dispatcher_instqueue_stall_in & ~empty & ~flush;
    end

    assign instqueue_if_full_out = full;
    assign instqueue_count_out   = count;

    // Storage array. It carries no reset: an entry is only ever read after
    // it has been written, since occupancy is tracked by count.
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            inst_mem[tail] <= if_instqueue_inst_in;
            pc_mem[tail]   <= if_instqueue_pc_in;
        end
    end

    // Pointers, occupancy and the registered issue stage. A flush wins over
    // everything, including a low rdy_in. With rdy_in low the queue freezes,
    // but the valid pulse is still dropped so that no entry is seen twice.
    // The issued inst/pc hold their last value when nothing is popped.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head                       <= '0;
            tail                       <= '0;
            count                      <= '0;
            instqueue_decoder_en_out   <= 1'b0;
            instqueue_decoder_inst_out <= '0;
            instqueue_decoder_pc_out   <= '0;
        end else if (flush) begin
            head                     <= '0;
            tail                     <= '0;
            count                    <= '0;
            instqueue_decoder_en_out <= 1'b0;
        end else begin
            instqueue_decoder_en_out <= do_pop;
            if (do_push) begin
                tail <= tail + 1'b1;
            end
            if (do_pop) begin
                head                       <= head + 1'b1;
                instqueue_decoder_inst_out <= inst_mem[head];
                instqueue_decoder_pc_out   <= pc_mem[head];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
